btb_update_ctrl: RTL and testbench

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_update_ctrl.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//
// Purpose:
//   Buffers resolved-branch updates in a small FIFO and writes them into the
//   branch target buffer one at a time. Each update is first searched in the
//   BTB (SEARCH), then written (WRITE) to the matching way, the lowest free
//   way, or the tree-pLRU victim. A flush aborts everything and clears every
//   BTB way, one way per cycle.
//
// Configuration:
//   BTB_UPD_COALESCE_EN - when defined, an update whose pc is already queued
//                         overwrites that entry's target instead of taking a
//                         new slot. Undefined by default.
//
// Ports:
//   clk, rst             - clock; asynchronous active-high reset
//   upd_valid/upd_ready  - update handshake; upd_pc/upd_target carried with it
//   hit_valid, hit_way   - fetch-side lookup hit, touches the pLRU
//   entry_valid          - current valid bit of each BTB way
//   srch_pc -> srch_hit, srch_way - combinational search of BTB storage
//   wr_en, wr_valid, wr_way, wr_pc, wr_target - BTB storage write port
//   flush                - invalidate all BTB ways
//   busy                 - FSM not IDLE
//   dbg_state            - current FSM state encoding
//
// Handshake: an update is accepted on a rising edge where upd_valid and
//   upd_ready are both high. upd_ready depends on registered state only.
// -----------------------------------------------------------------------------
module btb_update_ctrl #(
    parameter int BTB_DEPTH   = 4,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [31:0]                  upd_pc,
    input  logic [31:0]                  upd_target,
    input  logic                         hit_valid,
    input  logic [$clog2(BTB_DEPTH)-1:0] hit_way,
    input  logic [BTB_DEPTH-1:0]         entry_valid,
    output logic [31:0]                  srch_pc,
    input  logic                         srch_hit,
    input  logic [$clog2(BTB_DEPTH)-1:0] srch_way,
    output logic                         wr_en,
    output logic                         wr_valid,
    output logic [$clog2(BTB_DEPTH)-1:0] wr_way,
    output logic [31:0]                  wr_pc,
    output logic [31:0]                  wr_target,
    input  logic                         flush,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    localparam int WW = $clog2(BTB_DEPTH);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WRITE  = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t state, state_n;
    logic [WW-1:0] fcnt, fcnt_n;

    // Pending-update FIFO
    logic [31:0]   q_pc  [QUEUE_DEPTH];
    logic [31:0]   q_tgt [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          enq_fire, alloc, deq;

    // Search result captured at the end of SEARCH
    logic          srch_hit_q;
    logic [WW-1:0] srch_way_q;

    // Tree pLRU, heap order: node n has children 2n+1 (lower) and 2n+2 (upper)
    logic [BTB_DEPTH-2:0] plru, plru_n;
    logic [WW-1:0]        victim_way, free_way, sel_way;
    logic                 free_found;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QUEUE_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Point every node on w's path away from w.
    function automatic logic [BTB_DEPTH-2:0] plru_touch(input logic [BTB_DEPTH-2:0] t,
                                                        input logic [WW-1:0] w);
        logic [BTB_DEPTH-2:0] r;
        int node;
        r    = t;
        node = 0;
        for (int l = 0; l < WW; l++) begin
            r[node] = ~w[WW-1-l];
            node    = 2 * node + 1 + int'(w[WW-1-l]);
        end
        return r;
    endfunction

    // Follow the node bits from the root to the LRU leaf.
    function automatic logic [WW-1:0] plru_victim(input logic [BTB_DEPTH-2:0] t);
        logic [WW-1:0] v;
        logic b;
        int node;
        v    = '0;
        node = 0;
        for (int l = 0; l < WW; l++) begin
            b         = t[node];
            v[WW-1-l] = b;
            node      = 2 * node + 1 + int'(b);
        end
        return v;
    endfunction

    assign full      = (count == CW'(QUEUE_DEPTH));
    assign empty     = (count == '0);
    assign upd_ready = !full && (state != FLUSH);
    assign enq_fire  = upd_valid && upd_ready;
    // A flush in the WRITE cycle aborts the write, so nothing is dequeued.
    assign deq       = (state == WRITE) && !flush;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

`ifdef BTB_UPD_COALESCE_EN
    logic [QUEUE_DEPTH-1:0] q_occ;
    logic                   co_hit;
    logic [PW-1:0]          co_idx;

    // The head being written this cycle cannot absorb a new target; the
    // update then allocates a fresh slot instead.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (enq_fire && !co_hit && q_occ[i] && (q_pc[i] == upd_pc) &&
                !(deq && (PW'(i) == rd_ptr))) begin
                co_hit = 1'b1;
                co_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_occ <= '0;
        end else if (flush) begin
            q_occ <= '0;
        end else begin
            if (alloc) q_occ[wr_ptr] <= 1'b1;
            if (deq)   q_occ[rd_ptr] <= 1'b0;
        end
    end

    assign alloc = enq_fire && !co_hit;

    always_ff @(posedge clk) begin
        if (alloc) begin
            q_pc[wr_ptr]  <= upd_pc;
            q_tgt[wr_ptr] <= upd_target;
        end
        if (co_hit) q_tgt[co_idx] <= upd_target;
    end
`else
    assign alloc = enq_fire;

    always_ff @(posedge clk) begin
        if (alloc) begin
            q_pc[wr_ptr]  <= upd_pc;
            q_tgt[wr_ptr] <= upd_target;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc) wr_ptr <= ptr_inc(wr_ptr);
            if (deq)   rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(alloc) - CW'(deq);
        end
    end

    // Way selection: search hit, then lowest free way, then pLRU victim
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = BTB_DEPTH - 1; i >= 0; i--) begin
            if (!entry_valid[i]) begin
                free_found = 1'b1;
                free_way   = WW'(i);
            end
        end
    end

    assign victim_way = plru_victim(plru);

    always_comb begin
        if (srch_hit_q)      sel_way = srch_way_q;
        else if (free_found) sel_way = free_way;
        else                 sel_way = victim_way;
    end

    // The write touch is applied after the lookup touch so it wins on shared nodes.
    always_comb begin
        plru_n = plru;
        if (hit_valid && (state != FLUSH)) plru_n = plru_touch(plru_n, hit_way);
        if (deq)                           plru_n = plru_touch(plru_n, sel_way);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        plru <= '0;
        else if (flush) plru <= '0;
        else            plru <= plru_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srch_hit_q <= 1'b0;
            srch_way_q <= '0;
        end else if (state == SEARCH) begin
            srch_hit_q <= srch_hit;
            srch_way_q <= srch_way;
        end
    end

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        case (state)
            IDLE:   if (!empty) state_n = SEARCH;
            SEARCH: state_n = WRITE;
            WRITE:  state_n = IDLE;
            FLUSH: begin
                if (fcnt == WW'(BTB_DEPTH - 1)) begin
                    state_n = IDLE;
                    fcnt_n  = '0;
                end else begin
                    fcnt_n = fcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = FLUSH;
            fcnt_n  = '0;
        end
    end

    always_comb begin
        srch_pc   = '0;
        wr_en     = 1'b0;
        wr_valid  = 1'b0;
        wr_way    = '0;
        wr_pc     = '0;
        wr_target = '0;
        case (state)
            SEARCH: srch_pc = q_pc[rd_ptr];
            WRITE: begin
                if (!flush) begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_way    = sel_way;
                    wr_pc     = q_pc[rd_ptr];
                    wr_target = q_tgt[rd_ptr];
                end
            end
            FLUSH: begin
                wr_en  = 1'b1;
                wr_way = fcnt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid, upd_ready;
    logic [31:0] upd_pc, upd_target;
    logic        hit_valid;
    logic [1:0]  hit_way;
    logic [3:0]  entry_valid;
    logic [31:0] srch_pc;
    logic        srch_hit;
    logic [1:0]  srch_way;
    logic        wr_en, wr_valid;
    logic [1:0]  wr_way;
    logic [31:0] wr_pc, wr_target;
    logic        flush, busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // {way, pc, target}
    logic [65:0] exp_q[$];

    btb_update_ctrl #(.BTB_DEPTH(4), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target),
        .hit_valid(hit_valid), .hit_way(hit_way),
        .entry_valid(entry_valid),
        .srch_pc(srch_pc), .srch_hit(srch_hit), .srch_way(srch_way),
        .wr_en(wr_en), .wr_valid(wr_valid), .wr_way(wr_way),
        .wr_pc(wr_pc), .wr_target(wr_target),
        .flush(flush), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && wr_en && wr_valid) begin
            logic [65:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL write_unexpected: way=%0d pc=%h tgt=%h with no write expected",
                         wr_way, wr_pc, wr_target);
            end else begin
                e = exp_q.pop_front();
                if ({wr_way, wr_pc, wr_target} !== e) begin
                    n_errors++;
                    $display("FAIL write_data: way/pc/tgt=%0d/%h/%h required %0d/%h/%h",
                             wr_way, wr_pc, wr_target, e[65:64], e[63:32], e[31:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
        hit_valid = 1'b0; hit_way = '0; entry_valid = '0;
        srch_hit = 1'b0; srch_way = '0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [1:0] way, input bit push, output int hs_cyc);
        int k;
        k = 0;
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt;
        while (!upd_ready && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (!upd_ready) begin
            n_errors++;
            $display("FAIL send_ready: upd_ready=%b required 1 within 20 cycles", upd_ready);
        end else if (push) begin
            exp_q.push_back({way, pc, tgt});
        end
        hs_cyc = cyc;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 60) begin
            step();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0 || busy) begin
            n_errors++;
            $display("FAIL wait_idle: pending=%0d busy=%b required 0/0", exp_q.size(), busy);
        end
    endtask

    function automatic logic [31:0] rnd_pc();
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    // Tests
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({upd_ready, busy, wr_en, wr_valid} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_ctrl: ready/busy/wr_en/wr_valid=%b required 1000",
                     {upd_ready, busy, wr_en, wr_valid});
        end
        n_checks++;
        if ({wr_way, wr_pc, wr_target, srch_pc} !== 98'h0) begin
            n_errors++;
            $display("FAIL reset_data: way=%0d pc=%h tgt=%h srch=%h required all 0",
                     wr_way, wr_pc, wr_target, srch_pc);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d required 0", dbg_state);
        end
    endtask

    task automatic test_first_victim();
        int hs;
        do_reset();
        entry_valid = 4'b1111;
        send(32'h0000_4000, 32'h0000_5000, 2'd0, 1'b1, hs);
        wait_idle();
    endtask

    task automatic test_latency();
        int hs;
        do_reset();
        entry_valid = 4'b0000;
        send(32'h0000_1000, 32'h0000_2000, 2'd0, 1'b1, hs);
        @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL lat_n1: wr_en=%b required 0", wr_en);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({wr_en, srch_pc} !== {1'b0, 32'h0000_1000}) begin
            n_errors++;
            $display("FAIL lat_search: wr_en=%b srch_pc=%h required 0/00001000", wr_en, srch_pc);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({wr_en, wr_valid, busy} !== 3'b111 || cyc != hs + 3) begin
            n_errors++;
            $display("FAIL lat_write: wr_en/valid/busy=%b cycle=%0d required 111 at %0d",
                     {wr_en, wr_valid, busy}, cyc, hs + 3);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL lat_pulse: wr_en=%b required 0 after one write cycle", wr_en);
        end
        wait_idle();
    endtask

    task automatic test_plru();
        int hs;
        do_reset();
        entry_valid = 4'b1111;
        hit_valid = 1'b1; hit_way = 2'd0;
        step();
        hit_valid = 1'b0;
        send(rnd_pc(), rnd_pc(), 2'd2, 1'b1, hs); wait_idle();
        send(rnd_pc(), rnd_pc(), 2'd1, 1'b1, hs); wait_idle();
        send(rnd_pc(), rnd_pc(), 2'd3, 1'b1, hs); wait_idle();
        send(rnd_pc(), rnd_pc(), 2'd0, 1'b1, hs); wait_idle();
    endtask

    // Lookup touch and write touch in the same cycle: the write must win.
    task automatic test_touch_order();
        int hs;
        do_reset();
        entry_valid = 4'b1111;
        send(rnd_pc(), rnd_pc(), 2'd0, 1'b1, hs);
        step();
        step();
        hit_valid = 1'b1; hit_way = 2'd3;
        n_checks++;
        if (wr_en !== 1'b1) begin
            n_errors++;
            $display("FAIL touch_align: wr_en=%b required 1", wr_en);
        end
        step();
        hit_valid = 1'b0;
        wait_idle();
        send(rnd_pc(), rnd_pc(), 2'd2, 1'b1, hs);
        wait_idle();
    endtask

    task automatic test_way_select();
        int hs;
        do_reset();
        entry_valid = 4'b0001; srch_hit = 1'b1; srch_way = 2'd3;
        send(rnd_pc(), rnd_pc(), 2'd3, 1'b1, hs); wait_idle();
        srch_hit = 1'b0;
        entry_valid = 4'b0101;
        send(rnd_pc(), rnd_pc(), 2'd1, 1'b1, hs); wait_idle();
        entry_valid = 4'b1011;
        send(rnd_pc(), rnd_pc(), 2'd2, 1'b1, hs); wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] p [3];
        logic [1:0]  r [5];
        do_reset();
        entry_valid = 4'b1111;
        for (int i = 0; i < 3; i++) p[i] = rnd_pc();
        exp_q.push_back({2'd0, p[0], p[0] + 32'h40});
        exp_q.push_back({2'd2, p[1], p[1] + 32'h40});
        exp_q.push_back({2'd1, p[2], p[2] + 32'h40});
        upd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            upd_pc = p[(i < 2) ? i : 2];
            upd_target = upd_pc + 32'h40;
            r[i] = {upd_ready, wr_en};
            step();
        end
        upd_valid = 1'b0;
        // cycles N..N+4: ready high, high, low, low (first WRITE), high
        n_checks++;
        if ({r[0], r[1], r[2], r[3], r[4]} !== 10'b10_10_00_01_10) begin
            n_errors++;
            $display("FAIL b2b_ready: ready/wr_en per cycle=%b required 1010000110",
                     {r[0], r[1], r[2], r[3], r[4]});
        end
        wait_idle();
    endtask

    // Enqueue during the head's WRITE cycle: occupancy must stay at one.
    task automatic test_enq_deq();
        int hs;
        do_reset();
        entry_valid = 4'b1111;
        send(rnd_pc(), rnd_pc(), 2'd0, 1'b1, hs);
        step();
        step();
        n_checks++;
        if ({wr_en, upd_ready} !== 2'b11) begin
            n_errors++;
            $display("FAIL enq_deq_align: wr_en/ready=%b required 11", {wr_en, upd_ready});
        end
        send(rnd_pc(), rnd_pc(), 2'd2, 1'b1, hs);
        wait_idle();
        send(rnd_pc(), rnd_pc(), 2'd1, 1'b1, hs);
        wait_idle();
    endtask

    task automatic test_flush();
        int hs;
        logic [1:0] kw;
        do_reset();
        entry_valid = 4'b1111;
        hit_valid = 1'b1; hit_way = 2'd0;
        step();
        hit_valid = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h0000_A000; upd_target = 32'h0000_A100;
        step();
        upd_pc = 32'h0000_B000; upd_target = 32'h0000_B100;
        step();
        upd_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dbg_state, srch_pc} !== {2'd1, 32'h0000_A000}) begin
            n_errors++;
            $display("FAIL flush_search: state=%0d srch_pc=%h required 1/0000a000",
                     dbg_state, srch_pc);
        end
        step();
        flush = 1'b0; hit_valid = 1'b1; hit_way = 2'd0;
        for (int k = 0; k < 4; k++) begin
            kw = 2'(k);
            @(negedge clk);
            n_checks++;
            if ({wr_en, wr_valid, wr_way, wr_pc, wr_target, upd_ready} !==
                {1'b1, 1'b0, kw, 64'h0, 1'b0}) begin
                n_errors++;
                $display("FAIL flush_way%0d: en/valid/way/ready=%b/%b/%0d/%b pc=%h tgt=%h required 1/0/%0d/0 pc=0 tgt=0",
                         k, wr_en, wr_valid, wr_way, upd_ready, wr_pc, wr_target, k);
            end
            step();
        end
        hit_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, upd_ready, wr_en} !== 3'b010) begin
            n_errors++;
            $display("FAIL flush_end: busy/ready/wr_en=%b required 010", {busy, upd_ready, wr_en});
        end
        repeat (6) step();
        // pLRU cleared by flush and untouched by hits during flush
        send(rnd_pc(), rnd_pc(), 2'd0, 1'b1, hs);
        wait_idle();
    endtask

    task automatic test_flush_restart();
        logic [1:0] ways [7];
        ways = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 7; k++) begin
            flush = (k == 2);
            @(negedge clk);
            n_checks++;
            if ({wr_en, wr_valid, wr_way} !== {2'b10, ways[k]}) begin
                n_errors++;
                $display("FAIL flush_restart%0d: en/valid/way=%b/%b/%0d required 1/0/%0d",
                         k, wr_en, wr_valid, wr_way, ways[k]);
            end
            step();
        end
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_restart_end: busy=%b required 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        int hs;
        do_reset();
        send(32'h0000_C000, 32'h0000_C100, 2'd0, 1'b0, hs);
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wr_en, busy, upd_ready, srch_pc} !== {3'b001, 32'h0}) begin
            n_errors++;
            $display("FAIL rst_mid: wr_en/busy/ready=%b srch_pc=%h required 001/0",
                     {wr_en, busy, upd_ready}, srch_pc);
        end
        step();
        rst = 1'b0;
        repeat (6) step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_idle: busy=%b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_first_victim();
        test_latency();
        test_plru();
        test_touch_order();
        test_way_select();
        test_back_to_back();
        test_enq_deq();
        test_flush();
        test_flush_restart();
        test_rst_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL final_queue: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
